// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and defaults for the UART FIFO drain controller.
//   DRAIN_CNT_W   : default width of the sent-word statistics counter
//   drain_state_t : drain FSM state encoding (IDLE / READ / HOLD)
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DRAIN_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for a start condition
    ST_READ = 2'd1,  // read issued, FIFO data expected this cycle
    ST_HOLD = 2'd2   // word presented to the transmitter
  } drain_state_t;

endpackage

// File: rtl/uart_fifo_drain_ctrl.sv
// ---------------------------------------------------------------------------
// uart_fifo_drain_ctrl
// Drains words from an external FIFO (instantiated alongside by the parent)
// into a UART transmitter, one word at a time.
//
// Optional feature macro: UART_DRAIN_PARITY_DROP_EN
//   defined   : words arriving with i_fifo_parity_error=1 are discarded and
//               o_parity_drop pulses for one cycle.
//   undefined : parity error input is ignored, every word is forwarded,
//               o_parity_drop is tied low.
//
// Ports
//   i_clk, i_rst          : clock (rising edge), synchronous active-high reset
//   i_enable, i_cts       : both must be high to start a new FIFO read
//   i_fifo_empty          : FIFO empty flag
//   o_fifo_rd_req         : one-cycle read request (combinational)
//   i_fifo_data/_valid    : read data, valid one cycle after an accepted read
//   i_fifo_parity_error   : parity error flag of the word on i_fifo_data
//   o_tx_data/o_tx_valid  : word offered to the transmitter
//   i_tx_ready            : transmitter acceptance
//   o_busy                : FSM not idle
//   o_parity_drop         : one-cycle pulse per discarded word
//   o_rd_miss             : one-cycle pulse when a read returned no data
//   o_sent_cnt            : words handed to the transmitter (wrapping)
//   o_dbg_state           : current FSM state, for observation only
//
// Handshake: a TX word transfers on a rising edge where o_tx_valid and
// i_tx_ready are both high; once raised, o_tx_valid and o_tx_data stay
// stable until that transfer. A FIFO read is accepted on the rising edge
// where o_fifo_rd_req is high; i_fifo_valid must accompany the data in the
// following cycle or the read counts as a miss.
// ---------------------------------------------------------------------------
module uart_fifo_drain_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DW = 8,
  parameter int CNT_W   = DRAIN_CNT_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_cts,
  input  logic               i_fifo_empty,
  output logic               o_fifo_rd_req,
  input  logic [FIFO_DW-1:0] i_fifo_data,
  input  logic               i_fifo_valid,
  input  logic               i_fifo_parity_error,
  output logic [FIFO_DW-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_parity_drop,
  output logic               o_rd_miss,
  output logic [CNT_W-1:0]   o_sent_cnt,
  output logic [1:0]         o_dbg_state
);

  drain_state_t state;
  logic         start;
  logic         tx_handoff;
  logic         keep_word;

  always_comb begin
    start      = i_enable && i_cts && !i_fifo_empty;
    tx_handoff = (state == ST_HOLD) && i_tx_ready;
  end

`ifdef UART_DRAIN_PARITY_DROP_EN
  assign keep_word = !i_fifo_parity_error;
`else
  logic parity_err_unused;
  assign keep_word         = 1'b1;
  assign parity_err_unused = i_fifo_parity_error;
  assign o_parity_drop     = 1'b0;
`endif

  // The read request is issued in the same cycle the decision is made so the
  // FIFO data lands exactly while the FSM sits in READ. Gating with i_rst
  // keeps the request low during a reset cycle.
  assign o_fifo_rd_req = !i_rst && start && ((state == ST_IDLE) || tx_handoff);
  assign o_busy        = (state != ST_IDLE);
  assign o_dbg_state   = state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      o_tx_data  <= '0;
      o_tx_valid <= 1'b0;
      o_rd_miss  <= 1'b0;
      o_sent_cnt <= '0;
`ifdef UART_DRAIN_PARITY_DROP_EN
      o_parity_drop <= 1'b0;
`endif
    end else begin
      o_rd_miss <= 1'b0;
`ifdef UART_DRAIN_PARITY_DROP_EN
      o_parity_drop <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_READ;
        end
        ST_READ: begin
          if (!i_fifo_valid) begin
            o_rd_miss <= 1'b1;
            state     <= ST_IDLE;
          end else if (keep_word) begin
            o_tx_data  <= i_fifo_data;
            o_tx_valid <= 1'b1;
            state      <= ST_HOLD;
          end else begin
`ifdef UART_DRAIN_PARITY_DROP_EN
            o_parity_drop <= 1'b1;
`endif
            state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          // Enable/CTS only gate new reads; the held word always completes.
          if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
            o_sent_cnt <= o_sent_cnt + CNT_W'(1);
            state      <= start ? ST_READ : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_drain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_fifo_drain_ctrl
// Directed bench: a table of per-cycle vectors followed by hand-written
// sequences for stalls, CTS drop, parity handling, reset in HOLD, and
// counter wrap. A 4-bit counter is used so the wrap is reachable quickly.
// ---------------------------------------------------------------------------
module tb_uart_fifo_drain_ctrl;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          cts;
  logic          fifo_empty;
  logic          fifo_rd_req;
  logic [DW-1:0] fifo_data;
  logic          fifo_valid;
  logic          fifo_parity_error;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          parity_drop;
  logic          rd_miss;
  logic [CW-1:0] sent_cnt;
  logic [1:0]    dbg_state;

  int checks;
  int errors;
  logic [CW-1:0] exp_cnt;

  uart_fifo_drain_ctrl #(.FIFO_DW(DW), .CNT_W(CW)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_enable           (enable),
    .i_cts              (cts),
    .i_fifo_empty       (fifo_empty),
    .o_fifo_rd_req      (fifo_rd_req),
    .i_fifo_data        (fifo_data),
    .i_fifo_valid       (fifo_valid),
    .i_fifo_parity_error(fifo_parity_error),
    .o_tx_data          (tx_data),
    .o_tx_valid         (tx_valid),
    .i_tx_ready         (tx_ready),
    .o_busy             (busy),
    .o_parity_drop      (parity_drop),
    .o_rd_miss          (rd_miss),
    .o_sent_cnt         (sent_cnt),
    .o_dbg_state        (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst, en, cts, empty, fv;
    logic [DW-1:0] d;
    logic          pe, txr;
    logic          e_rd, e_txv;
    logic [DW-1:0] e_data;
    logic          e_busy, e_miss;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and settle before sampling.
  task automatic step(input logic r, input logic en, input logic c, input logic emp,
                      input logic fv, input logic [DW-1:0] d, input logic pe, input logic txr);
    @(negedge clk);
    rst = r; enable = en; cts = c; fifo_empty = emp;
    fifo_valid = fv; fifo_data = d; fifo_parity_error = pe; tx_ready = txr;
    #1;
  endtask

  // One complete word: request, read, hand-off, then an idle cycle where
  // the updated counter is checked.
  task automatic xfer(input logic [DW-1:0] d);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("xfer rd_req", 16'(fifo_rd_req), 16'd1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, d, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("xfer tx_data", 16'(tx_data), 16'(d));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    exp_cnt = exp_cnt + 1'b1;
    chk("xfer sent_cnt", 16'(sent_cnt), 16'(exp_cnt));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; enable = 1'b0; cts = 1'b0; fifo_empty = 1'b1;
    fifo_valid = 1'b0; fifo_data = '0; fifo_parity_error = 1'b0; tx_ready = 1'b0;
    repeat (3) @(posedge clk);

    //          rst   en    cts   empty fv    d      pe    txr   e_rd  e_txv e_data e_busy e_miss e_cnt
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 4'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 4'd1};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b0, 4'd1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA3, 1'b0, 1'b0, 4'd2};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA3, 1'b0, 1'b0, 4'd2};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA3, 1'b0, 1'b0, 4'd2};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA3, 1'b0, 1'b0, 4'd2};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA3, 1'b1, 1'b0, 4'd2};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA3, 1'b0, 1'b1, 4'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA3, 1'b0, 1'b0, 4'd2};

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].cts, vecs[i].empty,
           vecs[i].fv, vecs[i].d, vecs[i].pe, vecs[i].txr);
      chk($sformatf("vec%0d rd_req", i),   16'(fifo_rd_req), 16'(vecs[i].e_rd));
      chk($sformatf("vec%0d tx_valid", i), 16'(tx_valid),    16'(vecs[i].e_txv));
      chk($sformatf("vec%0d tx_data", i),  16'(tx_data),     16'(vecs[i].e_data));
      chk($sformatf("vec%0d busy", i),     16'(busy),        16'(vecs[i].e_busy));
      chk($sformatf("vec%0d rd_miss", i),  16'(rd_miss),     16'(vecs[i].e_miss));
      chk($sformatf("vec%0d sent_cnt", i), 16'(sent_cnt),    16'(vecs[i].e_cnt));
    end
    exp_cnt = 4'd2;

    // Transmitter stalls for 10 cycles in HOLD with more data waiting.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("stall rd_req start", 16'(fifo_rd_req), 16'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    chk("stall busy read", 16'(busy), 16'd1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk($sformatf("stall%0d tx_valid", i), 16'(tx_valid), 16'd1);
      chk($sformatf("stall%0d tx_data", i), 16'(tx_data), 16'h3C);
      chk($sformatf("stall%0d rd_req", i), 16'(fifo_rd_req), 16'd0);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("stall release rd_req", 16'(fifo_rd_req), 16'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    exp_cnt = exp_cnt + 1'b1;
    chk("stall sent_cnt", 16'(sent_cnt), 16'(exp_cnt));
    chk("stall tx_valid low", 16'(tx_valid), 16'd0);

    // CTS dropped while in HOLD: the word completes, no new read.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("cts hold tx_data", 16'(tx_data), 16'h11);
    chk("cts hold rd_req", 16'(fifo_rd_req), 16'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk($sformatf("cts low%0d rd_req", i), 16'(fifo_rd_req), 16'd0);
      chk($sformatf("cts low%0d busy", i), 16'(busy), 16'd0);
    end
    exp_cnt = exp_cnt + 1'b1;
    chk("cts sent_cnt", 16'(sent_cnt), 16'(exp_cnt));
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("cts restored rd_req", 16'(fifo_rd_req), 16'd1);
    // CTS also dropped during READ: the word is still captured.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("cts read tx_valid", 16'(tx_valid), 16'd1);
    chk("cts read tx_data", 16'(tx_data), 16'h22);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    exp_cnt = exp_cnt + 1'b1;
    chk("cts read sent_cnt", 16'(sent_cnt), 16'(exp_cnt));

    // Word 0x81 with a parity error.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("parity rd_req", 16'(fifo_rd_req), 16'd1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
`ifdef UART_DRAIN_PARITY_DROP_EN
    chk("parity drop pulse", 16'(parity_drop), 16'd1);
    chk("parity tx_valid", 16'(tx_valid), 16'd0);
    chk("parity busy", 16'(busy), 16'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("parity drop end", 16'(parity_drop), 16'd0);
    chk("parity tx_valid after", 16'(tx_valid), 16'd0);
    chk("parity sent_cnt", 16'(sent_cnt), 16'(exp_cnt));
`else
    chk("parity drop low", 16'(parity_drop), 16'd0);
    chk("parity fwd tx_valid", 16'(tx_valid), 16'd1);
    chk("parity fwd tx_data", 16'(tx_data), 16'h81);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("parity drop low2", 16'(parity_drop), 16'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    exp_cnt = exp_cnt + 1'b1;
    chk("parity fwd sent_cnt", 16'(sent_cnt), 16'(exp_cnt));
`endif

    // Reset while a word is held.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("rst hold tx_data", 16'(tx_data), 16'h5A);
    chk("rst rd_req gated", 16'(fifo_rd_req), 16'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst tx_valid", 16'(tx_valid), 16'd0);
    chk("rst tx_data", 16'(tx_data), 16'd0);
    chk("rst busy", 16'(busy), 16'd0);
    chk("rst rd_miss", 16'(rd_miss), 16'd0);
    chk("rst parity_drop", 16'(parity_drop), 16'd0);
    chk("rst sent_cnt", 16'(sent_cnt), 16'd0);
    chk("rst rd_req", 16'(fifo_rd_req), 16'd0);
    exp_cnt = '0;

    // Counter wrap: all-ones then back to zero.
    for (int i = 0; i < 16; i++) xfer(8'(i * 7 + 1));
    chk("wrap sent_cnt zero", 16'(sent_cnt), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
